// File: rtl/mem_pkg.sv
// Shared definitions for the word memory and its requester.
package mem_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int unsigned WORD_SHIFT  = 2;
  localparam int unsigned TRACK_TAG_W = 5;

  typedef struct packed {
    logic                   op;
    logic [TRACK_TAG_W-1:0] tag;
  } track_entry_t;

endpackage

// File: rtl/track_fifo.sv
// In-order tracking FIFO with wrap-bit pointers; storage is not reset.
module track_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/mem_requester.sv
// Pipeline-side master for the valid/ready word memory: issues requests,
// tracks them in order and returns load data with its tag.
module mem_requester
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = TRACK_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             req_valid,
  input  logic             req_ready,
  output logic             req_op,
  output logic [31:0]      req_addr,
  output logic [31:0]      req_wdata,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [31:0]      resp_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             err_misaligned,
  output logic             err_unexpected
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = TAG_W + 1;

  logic             misaligned;
  logic             accept;
  logic             accept_al;
  logic             pop;
  logic             unexpected;
  logic [EW-1:0]    fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             head_op;
  logic [TAG_W-1:0] head_tag;
  logic [CW-1:0]    inflight;

  assign misaligned = (cmd_addr[1:0] != 2'b00);
  assign cmd_ready  = (!req_valid || req_ready) && (inflight < CW'(DEPTH));
  assign accept     = cmd_valid && cmd_ready;
  assign accept_al  = accept && !misaligned;

  // Single request stage; a new command may replace an entry being issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid <= 1'b0;
      req_op    <= MEM_READ;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (accept_al) begin
      req_valid <= 1'b1;
      req_op    <= cmd_op;
      req_addr  <= cmd_addr >> WORD_SHIFT;
      req_wdata <= cmd_wdata;
    end else if (req_valid && req_ready) begin
      req_valid <= 1'b0;
    end
  end

  track_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_track (
    .clk   (clk),
    .reset (reset),
    .push  (accept_al),
    .din   ({cmd_op, cmd_tag}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_op  = fifo_dout[EW-1];
  assign head_tag = fifo_dout[TAG_W-1:0];
  assign rsp_data = resp_data;
  assign rsp_tag  = head_tag;

  // Steer memory responses by the oldest outstanding operation.
  always_comb begin
    pop        = 1'b0;
    unexpected = 1'b0;
    resp_ready = 1'b1;
    rsp_valid  = 1'b0;
    if (fifo_empty) begin
      unexpected = resp_valid;
    end else begin
      case (head_op)
        MEM_WRITE: pop = resp_valid;
        MEM_READ: begin
          rsp_valid  = resp_valid;
          resp_ready = rsp_ready;
          pop        = resp_valid && rsp_ready;
        end
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({accept_al, pop})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_misaligned <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (accept && misaligned) err_misaligned <= 1'b1;
      if (unexpected)           err_unexpected <= 1'b1;
    end
  end

  // The counter and the FIFO occupancy describe the same set of requests.
  a_count_match : assert property (@(posedge clk) disable iff (reset)
    (fifo_count == inflight) && (fifo_full == (inflight == CW'(DEPTH))));

endmodule

// File: tb/tb_mem_requester.sv
// Scoreboard bench for mem_requester with a behavioural word memory.
module tb_mem_requester;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [4:0]  cmd_tag;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        err_misaligned;
  logic        err_unexpected;

  int checks = 0;
  int errors = 0;

  track_entry_t exp_ops[$];
  logic [31:0]  exp_data[$];

  logic        hold;
  int          inj_req;
  int          inj_done;
  logic [31:0] mem [64];
  logic [31:0] rq[$];

  mem_requester #(.DEPTH(4), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_tag(cmd_tag),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag),
    .err_misaligned(err_misaligned), .err_unexpected(err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_cmd(input logic op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_tag   = tag;
  endtask

  task automatic wait_accept(input logic [31:0] expd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: addr %h never accepted", cmd_addr);
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    if (cmd_addr[1:0] == 2'b00) begin
      exp_ops.push_back(track_entry_t'{op: cmd_op, tag: cmd_tag});
      if (cmd_op == MEM_READ) exp_data.push_back(expd);
    end
  endtask

  task automatic send(input logic op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] tag, input logic [31:0] expd);
    drive_cmd(op, addr, wdata, tag);
    wait_accept(expd);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_ops.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d responses still outstanding", exp_ops.size());
    end
    tick();
  endtask

  // Behavioural memory: queues one response per issued request, presented in order.
  initial begin : memory
    bit          rst_s, f_req, f_op, f_resp, cur_inj;
    logic [31:0] f_addr, f_wd;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4]  = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) mem[8+i] = 32'h100 + 32'(i);
    mem[12] = 32'h200;
    mem[16] = 32'hCAFEF00D;
    resp_valid = 1'b0;
    resp_data  = '0;
    cur_inj    = 1'b0;
    inj_done   = 0;
    forever begin
      @(negedge clk);
      rst_s  = reset;
      f_req  = req_valid && req_ready;
      f_op   = req_op;
      f_addr = req_addr;
      f_wd   = req_wdata;
      f_resp = resp_valid && resp_ready;
      @(posedge clk);
      #1;
      if (rst_s) begin
        rq.delete();
      end else begin
        if (f_resp) begin
          if (cur_inj) inj_done++;
          else void'(rq.pop_front());
        end
        if (f_req) begin
          if (f_op == MEM_WRITE) begin
            mem[f_addr[5:0]] = f_wd;
            rq.push_back(32'h0);
          end else begin
            rq.push_back(mem[f_addr[5:0]]);
          end
        end
      end
      cur_inj = 1'b0;
      if (!hold && rq.size() > 0) begin
        resp_valid = 1'b1;
        resp_data  = rq[0];
      end else if (inj_req != inj_done) begin
        resp_valid = 1'b1;
        resp_data  = 32'h0BAD0BAD;
        cur_inj    = 1'b1;
      end else begin
        resp_valid = 1'b0;
      end
    end
  end

  // Monitor: every consumed memory response is matched against the oldest expectation.
  initial begin : monitor
    track_entry_t e;
    logic [31:0]  d;
    forever begin
      @(negedge clk);
      if (!reset && resp_valid && resp_ready) begin
        if (exp_ops.size() == 0) begin
          chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_ops.pop_front();
          if (e.op == MEM_WRITE) begin
            chk("store_rsp_silent", 32'(rsp_valid), 32'd0);
          end else begin
            d = exp_data.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_data", rsp_data, d);
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = MEM_READ;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_tag   = '0;
    req_ready = 1'b1;
    rsp_ready = 1'b1;
    hold      = 1'b0;
    inj_req   = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_op", 32'(req_op), 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_req_wdata", req_wdata, 32'd0);
    chk("rst_err_mis", 32'(err_misaligned), 32'd0);
    chk("rst_err_unexp", 32'(err_unexpected), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single load, address 0x10 -> word 4.
    send(MEM_READ, 32'h10, 32'h0, 5'd3, 32'hDEADBEEF);
    chk("load_req_valid", 32'(req_valid), 32'd1);
    chk("load_req_addr", req_addr, 32'd4);
    chk("load_req_op", 32'(req_op), 32'd0);
    wait_idle();

    // Store then load the same word.
    send(MEM_WRITE, 32'h8, 32'h55, 5'd0, 32'h0);
    chk("store_req_wdata", req_wdata, 32'h55);
    send(MEM_READ, 32'h8, 32'h0, 5'd7, 32'h55);
    wait_idle();

    // Fill all tracking entries with responses withheld.
    hold = 1'b1;
    for (int i = 0; i < 4; i++)
      send(MEM_READ, 32'h20 + 32'(4*i), 32'h0, 5'(10+i), 32'h100 + 32'(i));
    chk("full_inflight", 32'(dut.inflight), 32'd4);
    drive_cmd(MEM_READ, 32'h30, 32'h0, 5'd20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    tick();
    hold = 1'b0;
    wait_accept(32'h200);
    wait_idle();

    // Writeback backpressure on a pending load response.
    rsp_ready = 1'b0;
    send(MEM_READ, 32'h40, 32'h0, 5'd9, 32'hCAFEF00D);
    begin : bp
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      chk("bp_rsp_seen", 32'(seen), 32'd1);
      for (int i = 0; i < 5; i++) begin
        chk("bp_resp_ready", 32'(resp_ready), 32'd0);
        chk("bp_rsp_data", rsp_data, 32'hCAFEF00D);
        chk("bp_rsp_tag", 32'(rsp_tag), 32'd9);
        @(negedge clk);
      end
    end
    tick();
    rsp_ready = 1'b1;
    wait_idle();

    // Misaligned command is accepted but dropped.
    send(MEM_READ, 32'h6, 32'h0, 5'd1, 32'h0);
    chk("mis_err", 32'(err_misaligned), 32'd1);
    chk("mis_req_valid", 32'(req_valid), 32'd0);
    chk("mis_inflight", 32'(dut.inflight), 32'd0);
    send(MEM_READ, 32'h10, 32'h0, 5'd4, 32'hDEADBEEF);
    chk("after_mis_req_valid", 32'(req_valid), 32'd1);
    wait_idle();

    // Response with nothing outstanding.
    inj_req = inj_req + 1;
    repeat (4) tick();
    chk("unexp_err", 32'(err_unexpected), 32'd1);
    chk("unexp_consumed", 32'(inj_done), 32'd1);

    // Reset with two requests outstanding.
    hold = 1'b1;
    send(MEM_READ, 32'h20, 32'h0, 5'd1, 32'h100);
    send(MEM_READ, 32'h24, 32'h0, 5'd2, 32'h101);
    repeat (2) tick();
    reset = 1'b1;
    exp_ops.delete();
    exp_data.delete();
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_valid", 32'(req_valid), 32'd0);
    chk("mid_rst_req_addr", req_addr, 32'd0);
    chk("mid_rst_req_op", 32'(req_op), 32'd0);
    chk("mid_rst_req_wdata", req_wdata, 32'd0);
    chk("mid_rst_err_mis", 32'(err_misaligned), 32'd0);
    chk("mid_rst_err_unexp", 32'(err_unexpected), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_inflight", 32'(dut.inflight), 32'd0);
    tick();
    hold = 1'b0;
    repeat (5) tick();
    send(MEM_READ, 32'h10, 32'h0, 5'd6, 32'hDEADBEEF);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
